// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle controller: state encoding, writeback
// source codes, decoder one-hot bit positions and the registered opcode class.
package multicycle_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXEC    = 3'd3,
        S_MEM     = 3'd4,
        S_WB      = 3'd5,
        S_WAIT_IN = 3'd6
    } state_t;

    localparam logic [1:0] WB_ALU   = 2'd0;
    localparam logic [1:0] WB_DMEM  = 2'd1;
    localparam logic [1:0] WB_INPUT = 2'd2;
    localparam logic [1:0] WB_IMM   = 2'd3;

    localparam int DEC_W      = 23;
    localparam int BIT_NOOP   = 0;
    localparam int BIT_IN_LO  = 1;
    localparam int BIT_IN_HI  = 4;
    localparam int BIT_ALU_NF = 5;
    localparam int BIT_LOADI  = 6;
    localparam int BIT_LD_LO  = 11;
    localparam int BIT_LD_HI  = 12;
    localparam int BIT_ST_LO  = 13;
    localparam int BIT_ST_HI  = 14;
    localparam int BIT_CMP    = 17;
    localparam int BIT_JUMP   = 18;
    localparam int BIT_BRE    = 19;
    localparam int BIT_BRNE   = 20;
    localparam int BIT_BRG    = 21;
    localparam int BIT_BRGE   = 22;

    localparam logic [DEC_W-1:0] MASK_INPUT = 23'h00001E;
    localparam logic [DEC_W-1:0] MASK_ALU   = 23'h0187E0;  // bits 5-10, 15-16
    localparam logic [DEC_W-1:0] MASK_LOAD  = 23'h001800;
    localparam logic [DEC_W-1:0] MASK_STORE = 23'h006000;
    localparam logic [DEC_W-1:0] MASK_BR    = 23'h780000;

    typedef enum logic [3:0] {
        CLS_NOOP, CLS_INPUT, CLS_ALU, CLS_ALU_NF, CLS_LOADI,
        CLS_CMP, CLS_LOAD, CLS_STORE, CLS_JUMP, CLS_BR
    } cls_t;

    // Anything that is not exactly one-hot decays to NOOP.
    function automatic cls_t classify(input logic [DEC_W-1:0] d);
        cls_t c;
        c = CLS_NOOP;
        if (d == '0 || (d & (d - 1'b1)) != '0) c = CLS_NOOP;
        else if (d[BIT_NOOP])             c = CLS_NOOP;
        else if ((d & MASK_INPUT) != '0)  c = CLS_INPUT;
        else if (d[BIT_ALU_NF])           c = CLS_ALU_NF;
        else if (d[BIT_LOADI])            c = CLS_LOADI;
        else if ((d & MASK_ALU) != '0)    c = CLS_ALU;
        else if (d[BIT_CMP])              c = CLS_CMP;
        else if ((d & MASK_LOAD) != '0)   c = CLS_LOAD;
        else if ((d & MASK_STORE) != '0)  c = CLS_STORE;
        else if (d[BIT_JUMP])             c = CLS_JUMP;
        else if ((d & MASK_BR) != '0)     c = CLS_BR;
        return c;
    endfunction

endpackage

// File: rtl/branch_eval.sv
// Branch condition evaluator: ALU flags plus branch one-hot (BRE, BRNE, BRG, BRGE) -> taken.
module branch_eval (
    input  logic       i_flag_z,
    input  logic       i_flag_n,
    input  logic       i_flag_o,
    input  logic [3:0] i_br_onehot,
    output logic       o_taken
);
    logic w_ge;

    assign w_ge    = (i_flag_n == i_flag_o);
    assign o_taken = (i_br_onehot[0] &  i_flag_z)
                   | (i_br_onehot[1] & ~i_flag_z)
                   | (i_br_onehot[2] & ~i_flag_z & w_ge)
                   | (i_br_onehot[3] &  w_ge);
endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: sequences fetch/decode/execute/memory/writeback and
// an input-wait state with timeout; all strobes decode from state and opcode class.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int IN_TIMEOUT = 255,
    parameter int OPW        = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             step,
    input  logic [OPW-1:0]   opcode_in,
    input  logic [22:0]      dec_onehot,
    input  logic             flag_z,
    input  logic             flag_n,
    input  logic             flag_o,
    input  logic             in_valid,
    output logic [OPW-1:0]   opcode_ir,
    output logic             dec_en,
    output logic             imem_re,
    output logic             ir_we,
    output logic             pc_we,
    output logic             pc_sel,
    output logic             reg_re,
    output logic             alu_en,
    output logic             flags_we,
    output logic             dmem_re,
    output logic             dmem_we,
    output logic             reg_we,
    output logic [1:0]       wb_sel,
    output logic             in_ready,
    output logic             in_timeout,
    output logic [2:0]       state
);
    localparam int CNT_W = $clog2(IN_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IN_TIMEOUT - 1);

    state_t           r_state;
    state_t           w_next;
    state_t           w_end;
    cls_t             r_cls;
    cls_t             w_cls;
    logic [3:0]       r_br;
    logic [OPW-1:0]   r_ir;
    logic [CNT_W-1:0] r_cnt;
    logic             r_timeout;
    logic             w_taken;
    logic             w_cnt_last;

    assign w_cls      = classify(dec_onehot);
    assign w_end      = run ? S_FETCH : S_IDLE;
    assign w_cnt_last = (r_cnt == CNT_LAST);
    assign opcode_ir  = r_ir;
    assign in_timeout = r_timeout;
    assign state      = r_state;

    branch_eval u_branch_eval (
        .i_flag_z    (flag_z),
        .i_flag_n    (flag_n),
        .i_flag_o    (flag_o),
        .i_br_onehot (r_br),
        .o_taken     (w_taken)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_ir      <= '0;
            r_cls     <= CLS_NOOP;
            r_br      <= '0;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_FETCH) r_ir <= opcode_in;
            if (r_state == S_DECODE) begin
                r_cls <= w_cls;
                r_br  <= dec_onehot[BIT_BRGE:BIT_BRE];
                r_cnt <= '0;
            end
            if (r_state == S_WAIT_IN) begin
                r_cnt <= r_cnt + 1'b1;
                if (!in_valid && w_cnt_last) r_timeout <= 1'b1;
            end
        end
    end

    always_comb begin
        w_next   = r_state;
        dec_en   = 1'b0;
        imem_re  = 1'b0;
        ir_we    = 1'b0;
        pc_we    = 1'b0;
        pc_sel   = 1'b0;
        reg_re   = 1'b0;
        alu_en   = 1'b0;
        flags_we = 1'b0;
        dmem_re  = 1'b0;
        dmem_we  = 1'b0;
        reg_we   = 1'b0;
        wb_sel   = WB_ALU;
        in_ready = 1'b0;
        case (r_state)
            S_IDLE: if (run || step) w_next = S_FETCH;
            S_FETCH: begin
                imem_re = 1'b1;
                ir_we   = 1'b1;
                pc_we   = 1'b1;
                w_next  = S_DECODE;
            end
            S_DECODE: begin
                dec_en = 1'b1;
                reg_re = 1'b1;
                case (w_cls)
                    CLS_NOOP:  w_next = w_end;
                    CLS_INPUT: w_next = S_WAIT_IN;
                    default:   w_next = S_EXEC;
                endcase
            end
            S_EXEC: begin
                w_next = w_end;
                case (r_cls)
                    CLS_ALU: begin
                        alu_en   = 1'b1;
                        flags_we = 1'b1;
                        w_next   = S_WB;
                    end
                    CLS_ALU_NF, CLS_LOADI: begin
                        alu_en = 1'b1;
                        w_next = S_WB;
                    end
                    CLS_CMP: begin
                        alu_en   = 1'b1;
                        flags_we = 1'b1;
                    end
                    CLS_LOAD, CLS_STORE: w_next = S_MEM;
                    CLS_JUMP: begin
                        pc_we  = 1'b1;
                        pc_sel = 1'b1;
                    end
                    CLS_BR: begin
                        pc_we  = w_taken;
                        pc_sel = w_taken;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                if (r_cls == CLS_LOAD) begin
                    dmem_re = 1'b1;
                    w_next  = S_WB;
                end else begin
                    dmem_we = 1'b1;
                    w_next  = w_end;
                end
            end
            S_WB: begin
                reg_we = 1'b1;
                w_next = w_end;
                case (r_cls)
                    CLS_LOAD:  wb_sel = WB_DMEM;
                    CLS_INPUT: wb_sel = WB_INPUT;
                    CLS_LOADI: wb_sel = WB_IMM;
                    default:   wb_sel = WB_ALU;
                endcase
            end
            S_WAIT_IN: begin
                in_ready = 1'b1;
                if (in_valid || w_cnt_last) w_next = S_WB;
            end
            default: w_next = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class through the FSM.
module tb_multicycle_ctrl;
    localparam int TO = 10;

    logic        clk = 1'b0;
    logic        reset, run, step, in_valid;
    logic [7:0]  opcode_in;
    logic [22:0] dec_onehot;
    logic        flag_z, flag_n, flag_o;
    logic [7:0]  opcode_ir;
    logic        dec_en, imem_re, ir_we, pc_we, pc_sel, reg_re, alu_en, flags_we;
    logic        dmem_re, dmem_we, reg_we, in_ready, in_timeout;
    logic [1:0]  wb_sel;
    logic [2:0]  state;

    int total = 0;
    int bad   = 0;

    multicycle_ctrl #(.IN_TIMEOUT(TO), .OPW(8)) dut (
        .clk(clk), .reset(reset), .run(run), .step(step), .opcode_in(opcode_in),
        .dec_onehot(dec_onehot), .flag_z(flag_z), .flag_n(flag_n), .flag_o(flag_o),
        .in_valid(in_valid), .opcode_ir(opcode_ir), .dec_en(dec_en), .imem_re(imem_re),
        .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .reg_re(reg_re), .alu_en(alu_en),
        .flags_we(flags_we), .dmem_re(dmem_re), .dmem_we(dmem_we), .reg_we(reg_we),
        .wb_sel(wb_sel), .in_ready(in_ready), .in_timeout(in_timeout), .state(state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] strobes();
        return {dec_en, imem_re, ir_we, pc_we, pc_sel, reg_re, alu_en, flags_we,
                dmem_re, dmem_we, reg_we, in_ready};
    endfunction

    task automatic wait_idle(input string name);
        int n = 0;
        while (state !== 3'd0 && n < 20) begin
            tick();
            n++;
        end
        total++;
        if (state !== 3'd0) begin
            bad++;
            $display("FAIL %s_idle: state=%0d required 0", name, state);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        total++;
        if ({state, opcode_ir, in_timeout, wb_sel} !== 14'd0 || strobes() !== 12'd0) begin
            bad++;
            $display("FAIL reset_state: state=%0d ir=%h to=%b wb=%0d strobes=%h required all 0",
                     state, opcode_ir, in_timeout, wb_sel, strobes());
        end
        reset = 1'b0;
        tick();
        tick();
        total++;
        if (state !== 3'd0) begin
            bad++;
            $display("FAIL idle_hold: state=%0d required 0", state);
        end
    endtask

    task automatic test_add();
        dec_onehot = 23'd1 << 7;
        opcode_in  = 8'hA7;
        run = 1'b1;
        tick();
        total++;
        if (state !== 3'd1 || imem_re !== 1'b1 || ir_we !== 1'b1 || pc_we !== 1'b1 || pc_sel !== 1'b0) begin
            bad++;
            $display("FAIL add_fetch: state=%0d im=%b ir=%b pcwe=%b pcsel=%b required 1 1 1 1 0",
                     state, imem_re, ir_we, pc_we, pc_sel);
        end
        tick();
        total++;
        if (state !== 3'd2 || opcode_ir !== 8'hA7 || dec_en !== 1'b1 || reg_re !== 1'b1) begin
            bad++;
            $display("FAIL add_decode: state=%0d ir=%h dec_en=%b reg_re=%b required 2 a7 1 1",
                     state, opcode_ir, dec_en, reg_re);
        end
        tick();
        total++;
        if (state !== 3'd3 || alu_en !== 1'b1 || flags_we !== 1'b1 || pc_we !== 1'b0) begin
            bad++;
            $display("FAIL add_exec: state=%0d alu=%b flags=%b pc_we=%b required 3 1 1 0",
                     state, alu_en, flags_we, pc_we);
        end
        tick();
        total++;
        if (state !== 3'd5 || reg_we !== 1'b1 || wb_sel !== 2'd0) begin
            bad++;
            $display("FAIL add_wb: state=%0d reg_we=%b wb_sel=%0d required 5 1 0", state, reg_we, wb_sel);
        end
        tick();
        total++;
        if (state !== 3'd1) begin
            bad++;
            $display("FAIL add_next: state=%0d required 1", state);
        end
        run = 1'b0;
        tick();
        tick();
        tick();
        total++;
        if (state !== 3'd5) begin
            bad++;
            $display("FAIL add_finish: state=%0d required 5", state);
        end
        tick();
        total++;
        if (state !== 3'd0) begin
            bad++;
            $display("FAIL add_stop: state=%0d required 0", state);
        end
    endtask

    task automatic test_noop();
        logic [22:0] pats [2];
        pats[0] = 23'd0;
        pats[1] = 23'h000003;
        for (int p = 0; p < 2; p++) begin
            dec_onehot = pats[p];
            run = 1'b1;
            tick();
            tick();
            tick();
            total++;
            if (state !== 3'd1) begin
                bad++;
                $display("FAIL noop_%0d: state=%0d required 1", p, state);
            end
            run = 1'b0;
            tick();
            tick();
            total++;
            if (state !== 3'd0) begin
                bad++;
                $display("FAIL noop_%0d_end: state=%0d required 0", p, state);
            end
        end
    endtask

    task automatic test_load_store();
        int n_we, n_reg, cyc;
        dec_onehot = 23'd1 << 11;
        run = 1'b1;
        tick();
        tick();
        tick();
        run = 1'b0;
        total++;
        if (state !== 3'd3 || dmem_re !== 1'b0) begin
            bad++;
            $display("FAIL load_exec: state=%0d dmem_re=%b required 3 0", state, dmem_re);
        end
        tick();
        total++;
        if (state !== 3'd4 || dmem_re !== 1'b1 || dmem_we !== 1'b0) begin
            bad++;
            $display("FAIL load_mem: state=%0d re=%b we=%b required 4 1 0", state, dmem_re, dmem_we);
        end
        tick();
        total++;
        if (state !== 3'd5 || reg_we !== 1'b1 || wb_sel !== 2'd1) begin
            bad++;
            $display("FAIL load_wb: state=%0d reg_we=%b wb_sel=%0d required 5 1 1", state, reg_we, wb_sel);
        end
        tick();
        total++;
        if (state !== 3'd0) begin
            bad++;
            $display("FAIL load_end: state=%0d required 0", state);
        end
        dec_onehot = 23'd1 << 13;
        run = 1'b1;
        tick();
        run = 1'b0;
        n_we = 0;
        n_reg = 0;
        cyc = 0;
        while (state !== 3'd0 && cyc < 20) begin
            if (dmem_we === 1'b1) n_we++;
            if (reg_we === 1'b1) n_reg++;
            cyc++;
            tick();
        end
        total++;
        if (n_we != 1 || n_reg != 0 || cyc != 4) begin
            bad++;
            $display("FAIL store: dmem_we=%0d reg_we=%0d cycles=%0d required 1 0 4", n_we, n_reg, cyc);
        end
    endtask

    task automatic test_branch();
        int          bits  [7] = '{19, 19, 20, 21, 21, 22, 18};
        logic [2:0]  flg   [7] = '{3'b100, 3'b000, 3'b000, 3'b011, 3'b111, 3'b010, 3'b000};
        logic        taken [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 7; i++) begin
            dec_onehot = 23'd1 << bits[i];
            {flag_z, flag_n, flag_o} = flg[i];
            run = 1'b1;
            tick();
            run = 1'b0;
            tick();
            tick();
            total++;
            if (state !== 3'd3 || pc_we !== taken[i] || pc_sel !== taken[i] || reg_we !== 1'b0) begin
                bad++;
                $display("FAIL branch_b%0d_%0d: state=%0d pc_we=%b pc_sel=%b required 3 %b %b",
                         bits[i], i, state, pc_we, pc_sel, taken[i], taken[i]);
            end
            tick();
            total++;
            if (state !== 3'd0) begin
                bad++;
                $display("FAIL branch_end_%0d: state=%0d required 0", i, state);
            end
        end
        {flag_z, flag_n, flag_o} = 3'b000;
    endtask

    task automatic test_input();
        int n_rdy;
        dec_onehot = 23'd1 << 1;
        run = 1'b1;
        tick();
        run = 1'b0;
        tick();
        tick();
        n_rdy = 0;
        for (int i = 0; i < 5; i++) begin
            if (state === 3'd6 && in_ready === 1'b1) n_rdy++;
            if (i == 4) in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        total++;
        if (n_rdy != 5 || state !== 3'd5 || wb_sel !== 2'd2 || reg_we !== 1'b1 || in_timeout !== 1'b0) begin
            bad++;
            $display("FAIL input_valid: ready=%0d state=%0d wb=%0d reg_we=%b to=%b required 5 5 2 1 0",
                     n_rdy, state, wb_sel, reg_we, in_timeout);
        end
        wait_idle("input_valid");
        run = 1'b1;
        tick();
        run = 1'b0;
        tick();
        tick();
        n_rdy = 0;
        while (state === 3'd6 && n_rdy < 40) begin
            n_rdy++;
            tick();
        end
        total++;
        if (n_rdy != TO || state !== 3'd5 || wb_sel !== 2'd2 || in_timeout !== 1'b1) begin
            bad++;
            $display("FAIL input_timeout: wait=%0d state=%0d wb=%0d to=%b required %0d 5 2 1",
                     n_rdy, state, wb_sel, in_timeout, TO);
        end
        wait_idle("input_timeout");
        total++;
        if (in_timeout !== 1'b1) begin
            bad++;
            $display("FAIL timeout_sticky: to=%b required 1", in_timeout);
        end
    endtask

    task automatic test_step();
        dec_onehot = 23'd1 << 7;
        step = 1'b1;
        tick();
        step = 1'b0;
        total++;
        if (state !== 3'd1) begin
            bad++;
            $display("FAIL step_fetch: state=%0d required 1", state);
        end
        tick();
        tick();
        step = 1'b1;
        tick();
        step = 1'b0;
        total++;
        if (state !== 3'd5) begin
            bad++;
            $display("FAIL step_wb: state=%0d required 5", state);
        end
        tick();
        tick();
        tick();
        total++;
        if (state !== 3'd0) begin
            bad++;
            $display("FAIL step_ignored: state=%0d required 0", state);
        end
    endtask

    task automatic test_reset_mid();
        dec_onehot = 23'd1 << 13;
        opcode_in  = 8'h5C;
        run = 1'b1;
        tick();
        tick();
        tick();
        tick();
        total++;
        if (state !== 3'd4 || dmem_we !== 1'b1 || opcode_ir !== 8'h5C) begin
            bad++;
            $display("FAIL mid_mem: state=%0d dmem_we=%b ir=%h required 4 1 5c", state, dmem_we, opcode_ir);
        end
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (state !== 3'd0 || dmem_we !== 1'b0 || opcode_ir !== 8'h00 || in_timeout !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset: state=%0d dmem_we=%b ir=%h to=%b required 0 0 00 0",
                     state, dmem_we, opcode_ir, in_timeout);
        end
        run = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        total++;
        if (state !== 3'd0) begin
            bad++;
            $display("FAIL mid_release: state=%0d required 0", state);
        end
    endtask

    initial begin
        reset = 1'b1;
        run = 1'b0;
        step = 1'b0;
        in_valid = 1'b0;
        opcode_in = 8'h00;
        dec_onehot = '0;
        {flag_z, flag_n, flag_o} = 3'b000;
        test_reset();
        test_add();
        test_noop();
        test_load_store();
        test_branch();
        test_input();
        test_step();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
